// File: rtl/lc4_iq_pkg.sv
// Shared definitions for the LC4 instruction queue and the memory-ordering selector.
package lc4_iq_pkg;
    localparam int IQ_DEPTH  = 4;
    localparam int IQ_IDX_W  = 2;
    localparam int IQ_INSN_W = 16;
    localparam int IQ_PC_W   = 16;

    typedef struct packed {
        logic [IQ_INSN_W-1:0] insn;
        logic [IQ_PC_W-1:0]   pc;
        logic                 valid;
        logic                 issue;
        logic                 commit;
    } iq_slot_t;
endpackage

// File: rtl/lc4_insn_queue_if.sv
// Decode/issue/commit/retire bundle for lc4_insn_queue.
// LC4_IQ_DUAL_RETIRE_EN adds the second retire port.
interface lc4_insn_queue_if #(
    parameter int INSN_W = 16,
    parameter int PC_W   = 16
);
    logic              in_valid;
    logic [INSN_W-1:0] in_insn;
    logic [PC_W-1:0]   in_pc;
    logic              in_ready;
    logic              issue_en;
    logic [1:0]        issue_index;
    logic              commit_en;
    logic [1:0]        commit_index;
    logic              flush;
    logic [INSN_W-1:0] iq0_insn, iq1_insn, iq2_insn, iq3_insn;
    logic [PC_W-1:0]   iq0_pc, iq1_pc, iq2_pc, iq3_pc;
    logic [3:0]        iq_valid, iq_issue, iq_commit;
    logic [1:0]        iq_rd, iq_wr;
    logic [2:0]        iq_count;
    logic              retire_valid;
    logic [PC_W-1:0]   retire_pc;
`ifdef LC4_IQ_DUAL_RETIRE_EN
    logic              retire2_valid;
    logic [PC_W-1:0]   retire2_pc;
`endif

    modport master (
        output in_valid, in_insn, in_pc, issue_en, issue_index,
               commit_en, commit_index, flush,
        input  in_ready, iq0_insn, iq1_insn, iq2_insn, iq3_insn,
               iq0_pc, iq1_pc, iq2_pc, iq3_pc, iq_valid, iq_issue, iq_commit,
               iq_rd, iq_wr, iq_count, retire_valid, retire_pc
`ifdef LC4_IQ_DUAL_RETIRE_EN
        , input retire2_valid, retire2_pc
`endif
    );

    modport slave (
        input  in_valid, in_insn, in_pc, issue_en, issue_index,
               commit_en, commit_index, flush,
        output in_ready, iq0_insn, iq1_insn, iq2_insn, iq3_insn,
               iq0_pc, iq1_pc, iq2_pc, iq3_pc, iq_valid, iq_issue, iq_commit,
               iq_rd, iq_wr, iq_count, retire_valid, retire_pc
`ifdef LC4_IQ_DUAL_RETIRE_EN
        , output retire2_valid, retire2_pc
`endif
    );
endinterface

// File: rtl/lc4_iq_slot.sv
// One queue entry: instruction/PC payload plus valid/issue/commit state.
module lc4_iq_slot
    import lc4_iq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_wr_en,
    input  logic [IQ_INSN_W-1:0] i_insn,
    input  logic [IQ_PC_W-1:0]   i_pc,
    input  logic                 i_issue_set,
    input  logic                 i_commit_set,
    input  logic                 i_retire_clr,
    output iq_slot_t             o_slot
);
    iq_slot_t r_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else if (i_flush) begin
            // payload survives a flush; consumers qualify it with valid
            r_slot.valid  <= 1'b0;
            r_slot.issue  <= 1'b0;
            r_slot.commit <= 1'b0;
        end else if (i_wr_en) begin
            r_slot.insn   <= i_insn;
            r_slot.pc     <= i_pc;
            r_slot.valid  <= 1'b1;
            r_slot.issue  <= 1'b0;
            r_slot.commit <= 1'b0;
        end else if (i_retire_clr) begin
            r_slot.valid  <= 1'b0;
            r_slot.issue  <= 1'b0;
            r_slot.commit <= 1'b0;
        end else begin
            if (i_issue_set && r_slot.valid)
                r_slot.issue <= 1'b1;
            // commit checks the registered issue bit, so a same-cycle issue does not count
            if (i_commit_set && r_slot.valid && r_slot.issue)
                r_slot.commit <= 1'b1;
        end
    end

    assign o_slot = r_slot;
endmodule

// File: rtl/lc4_insn_queue.sv
// Four-entry in-order-retire instruction queue for the OoO LC4 core.
// LC4_IQ_DUAL_RETIRE_EN enables retiring two committed head entries per cycle.
module lc4_insn_queue
    import lc4_iq_pkg::*;
#(
    parameter int INSN_W = IQ_INSN_W,
    parameter int PC_W   = IQ_PC_W
) (
    input  logic             clk,
    input  logic             rst,
    lc4_insn_queue_if.slave  io_q
);
    logic [IQ_IDX_W-1:0] r_rd, r_wr, w_rd1;
    logic [2:0]          r_cnt;
    logic                w_ready, w_enq, w_ret0, w_ret1;
    logic [INSN_W-1:0]   w_insn;
    logic [PC_W-1:0]     w_pc;
    iq_slot_t            w_slot [IQ_DEPTH];
    logic [3:0]          w_vld, w_iss, w_com;

    assign w_insn  = io_q.in_insn;
    assign w_pc    = io_q.in_pc;
    assign w_ready = (r_cnt != 3'd4);
    assign w_enq   = io_q.in_valid && w_ready && !io_q.flush && !rst;
    assign w_rd1   = r_rd + 2'd1;

    // head is eligible once its commit bit is registered; flush/rst suppress retire
    assign w_ret0 = w_slot[r_rd].valid && w_slot[r_rd].commit && !io_q.flush && !rst;
`ifdef LC4_IQ_DUAL_RETIRE_EN
    assign w_ret1 = w_ret0 && w_slot[w_rd1].valid && w_slot[w_rd1].commit;
`else
    assign w_ret1 = 1'b0;
`endif

    for (genvar g = 0; g < IQ_DEPTH; g++) begin : g_slot
        logic w_wr_en, w_iss_set, w_com_set, w_ret_clr;
        assign w_wr_en   = w_enq && (r_wr == IQ_IDX_W'(g));
        assign w_iss_set = io_q.issue_en && (io_q.issue_index == IQ_IDX_W'(g));
        assign w_com_set = io_q.commit_en && (io_q.commit_index == IQ_IDX_W'(g));
        assign w_ret_clr = (w_ret0 && (r_rd == IQ_IDX_W'(g))) ||
                           (w_ret1 && (w_rd1 == IQ_IDX_W'(g)));

        lc4_iq_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_flush      (io_q.flush),
            .i_wr_en      (w_wr_en),
            .i_insn       (w_insn),
            .i_pc         (w_pc),
            .i_issue_set  (w_iss_set),
            .i_commit_set (w_com_set),
            .i_retire_clr (w_ret_clr),
            .o_slot       (w_slot[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || io_q.flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + {1'b0, w_enq};
            r_rd  <= r_rd + {1'b0, w_ret0} + {1'b0, w_ret1};
            r_cnt <= r_cnt + {2'b0, w_enq} - {2'b0, w_ret0} - {2'b0, w_ret1};
        end
    end

    always_comb begin
        w_vld = '0;
        w_iss = '0;
        w_com = '0;
        for (int k = 0; k < IQ_DEPTH; k++) begin
            w_vld[k] = w_slot[k].valid;
            w_iss[k] = w_slot[k].issue;
            w_com[k] = w_slot[k].commit;
        end
    end

    assign io_q.in_ready     = w_ready;
    assign io_q.iq0_insn     = w_slot[0].insn;
    assign io_q.iq1_insn     = w_slot[1].insn;
    assign io_q.iq2_insn     = w_slot[2].insn;
    assign io_q.iq3_insn     = w_slot[3].insn;
    assign io_q.iq0_pc       = w_slot[0].pc;
    assign io_q.iq1_pc       = w_slot[1].pc;
    assign io_q.iq2_pc       = w_slot[2].pc;
    assign io_q.iq3_pc       = w_slot[3].pc;
    assign io_q.iq_valid     = w_vld;
    assign io_q.iq_issue     = w_iss;
    assign io_q.iq_commit    = w_com;
    assign io_q.iq_rd        = r_rd;
    assign io_q.iq_wr        = r_wr;
    assign io_q.iq_count     = r_cnt;
    assign io_q.retire_valid = w_ret0;
    assign io_q.retire_pc    = w_ret0 ? w_slot[r_rd].pc : '0;
`ifdef LC4_IQ_DUAL_RETIRE_EN
    assign io_q.retire2_valid = w_ret1;
    assign io_q.retire2_pc    = w_ret1 ? w_slot[w_rd1].pc : '0;
`endif
endmodule

// File: tb/tb_lc4_insn_queue.sv
// Directed bench for lc4_insn_queue: per-cycle check against a behavioural model plus literal checkpoints.
module tb_lc4_insn_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc4_insn_queue_if #(.INSN_W(16), .PC_W(16)) q ();
    lc4_insn_queue #(.INSN_W(16), .PC_W(16)) dut (.clk(clk), .rst(rst), .io_q(q));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: four entries, head/tail slot numbers and occupancy
    logic [15:0] m_insn [4];
    logic [15:0] m_pc   [4];
    bit   m_v [4];
    bit   m_i [4];
    bit   m_c [4];
    int   m_rd, m_wr, m_cnt;
    bit   m_init = 0;

    function automatic logic [3:0] pk(input bit a0, input bit a1, input bit a2, input bit a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic bit m_r1();
        return !rst && !q.flush && m_v[m_rd] && m_c[m_rd];
    endfunction

    function automatic bit m_r2();
`ifdef LC4_IQ_DUAL_RETIRE_EN
        return m_r1() && m_v[(m_rd + 1) % 4] && m_c[(m_rd + 1) % 4];
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_insn[k] = '0; m_pc[k] = '0; m_v[k] = 0; m_i[k] = 0; m_c[k] = 0;
            end
            m_rd = 0; m_wr = 0; m_cnt = 0; m_init = 1;
        end else if (m_init && q.flush) begin
            for (int k = 0; k < 4; k++) begin
                m_v[k] = 0; m_i[k] = 0; m_c[k] = 0;
            end
            m_rd = 0; m_wr = 0; m_cnt = 0;
        end else if (m_init) begin
            bit r1, r2, enq, cm;
            int ii, ci;
            r1  = m_r1();
            r2  = m_r2();
            enq = q.in_valid && (m_cnt != 4);
            ii  = int'(q.issue_index);
            ci  = int'(q.commit_index);
            cm  = q.commit_en && m_v[ci] && m_i[ci];
            if (q.issue_en && m_v[ii]) m_i[ii] = 1;
            if (cm) m_c[ci] = 1;
            if (r1) begin m_v[m_rd] = 0; m_i[m_rd] = 0; m_c[m_rd] = 0; end
            if (r2) begin m_v[(m_rd+1)%4] = 0; m_i[(m_rd+1)%4] = 0; m_c[(m_rd+1)%4] = 0; end
            if (enq) begin
                m_insn[m_wr] = q.in_insn; m_pc[m_wr] = q.in_pc;
                m_v[m_wr] = 1; m_i[m_wr] = 0; m_c[m_wr] = 0;
                m_wr = (m_wr + 1) % 4;
            end
            m_rd  = (m_rd + int'(r1) + int'(r2)) % 4;
            m_cnt = m_cnt + int'(enq) - int'(r1) - int'(r2);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready",  32'(q.in_ready), 32'(m_cnt != 4));
            chk("iq_valid",  32'(q.iq_valid), 32'(pk(m_v[0], m_v[1], m_v[2], m_v[3])));
            chk("iq_issue",  32'(q.iq_issue), 32'(pk(m_i[0], m_i[1], m_i[2], m_i[3])));
            chk("iq_commit", 32'(q.iq_commit), 32'(pk(m_c[0], m_c[1], m_c[2], m_c[3])));
            chk("iq_rd",     32'(q.iq_rd), 32'(m_rd));
            chk("iq_wr",     32'(q.iq_wr), 32'(m_wr));
            chk("iq_count",  32'(q.iq_count), 32'(m_cnt));
            chk("retire_valid", 32'(q.retire_valid), 32'(m_r1()));
            chk("retire_pc", 32'(q.retire_pc), m_r1() ? 32'(m_pc[m_rd]) : 32'd0);
`ifdef LC4_IQ_DUAL_RETIRE_EN
            chk("retire2_valid", 32'(q.retire2_valid), 32'(m_r2()));
            chk("retire2_pc", 32'(q.retire2_pc), m_r2() ? 32'(m_pc[(m_rd+1)%4]) : 32'd0);
`endif
            chk("iq0_insn", 32'(q.iq0_insn), 32'(m_insn[0]));
            chk("iq1_insn", 32'(q.iq1_insn), 32'(m_insn[1]));
            chk("iq2_insn", 32'(q.iq2_insn), 32'(m_insn[2]));
            chk("iq3_insn", 32'(q.iq3_insn), 32'(m_insn[3]));
            chk("iq0_pc", 32'(q.iq0_pc), 32'(m_pc[0]));
            chk("iq1_pc", 32'(q.iq1_pc), 32'(m_pc[1]));
            chk("iq2_pc", 32'(q.iq2_pc), 32'(m_pc[2]));
            chk("iq3_pc", 32'(q.iq3_pc), 32'(m_pc[3]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        q.in_valid  = 0;
        q.issue_en  = 0;
        q.commit_en = 0;
        q.flush     = 0;
    endtask

    task automatic enq(input logic [15:0] insn, input logic [15:0] pc);
        q.in_valid = 1; q.in_insn = insn; q.in_pc = pc;
        tick();
    endtask

    task automatic iss(input logic [1:0] idx);
        q.issue_en = 1; q.issue_index = idx;
        tick();
    endtask

    task automatic com(input logic [1:0] idx);
        q.commit_en = 1; q.commit_index = idx;
        tick();
    endtask

    initial begin
        q.in_valid = 0; q.in_insn = '0; q.in_pc = '0;
        q.issue_en = 0; q.issue_index = '0;
        q.commit_en = 0; q.commit_index = '0;
        q.flush = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk("rst count", 32'(q.iq_count), 32'd0);
        chk("rst ready", 32'(q.in_ready), 32'd1);
        chk("rst valid", 32'(q.iq_valid), 32'd0);

        for (int k = 0; k < 4; k++) enq(16'hA000 | 16'(k), 16'h0010 + 16'(k));
        chk("full valid", 32'(q.iq_valid), 32'hF);
        chk("full count", 32'(q.iq_count), 32'd4);
        chk("full ready", 32'(q.in_ready), 32'd0);
        chk("full wr", 32'(q.iq_wr), 32'd0);

        enq(16'hBEEF, 16'h0099);
        chk("drop pc0", 32'(q.iq0_pc), 32'h10);
        chk("drop count", 32'(q.iq_count), 32'd4);

        iss(2'd1); com(2'd1);
        chk("c1 commit", 32'(q.iq_commit), 32'b0010);
        chk("c1 no retire", 32'(q.retire_valid), 32'd0);

        iss(2'd0); com(2'd0);
        chk("ret0 valid", 32'(q.retire_valid), 32'd1);
        chk("ret0 pc", 32'(q.retire_pc), 32'h10);
`ifdef LC4_IQ_DUAL_RETIRE_EN
        chk("ret2 valid", 32'(q.retire2_valid), 32'd1);
        chk("ret2 pc", 32'(q.retire2_pc), 32'h11);
        tick();
`else
        tick();
        chk("ret1 valid", 32'(q.retire_valid), 32'd1);
        chk("ret1 pc", 32'(q.retire_pc), 32'h11);
        chk("ret1 rd", 32'(q.iq_rd), 32'd1);
        tick();
`endif
        chk("post ret valid", 32'(q.retire_valid), 32'd0);
        chk("post ret rd", 32'(q.iq_rd), 32'd2);
        chk("post ret count", 32'(q.iq_count), 32'd2);

        com(2'd2);
        chk("c2 no issue", 32'(q.iq_commit[2]), 32'd0);

        q.issue_en = 1; q.issue_index = 2'd3;
        q.commit_en = 1; q.commit_index = 2'd3;
        tick();
        chk("same iss", 32'(q.iq_issue[3]), 32'd1);
        chk("same com", 32'(q.iq_commit[3]), 32'd0);

        enq(16'hC000, 16'h0020);
        enq(16'hC001, 16'h0021);
        chk("wrap rd", 32'(q.iq_rd), 32'd2);
        chk("wrap wr", 32'(q.iq_wr), 32'd2);
        chk("wrap count", 32'(q.iq_count), 32'd4);
        chk("wrap pc0", 32'(q.iq0_pc), 32'h20);
        chk("wrap pc1", 32'(q.iq1_pc), 32'h21);

        iss(2'd2); com(2'd2); com(2'd3);
        chk("pre flush ret", 32'(q.retire_valid), 32'd1);
        chk("pre flush pc", 32'(q.retire_pc), 32'h13);
        chk("pre flush ready", 32'(q.in_ready), 32'd1);

        q.flush = 1;
        q.in_valid = 1; q.in_insn = 16'hDEAD; q.in_pc = 16'h0055;
        q.issue_en = 1; q.issue_index = 2'd0;
        #1;
        chk("flush ret gate", 32'(q.retire_valid), 32'd0);
        tick();
        chk("flush valid", 32'(q.iq_valid), 32'd0);
        chk("flush issue", 32'(q.iq_issue), 32'd0);
        chk("flush commit", 32'(q.iq_commit), 32'd0);
        chk("flush rd", 32'(q.iq_rd), 32'd0);
        chk("flush wr", 32'(q.iq_wr), 32'd0);
        chk("flush count", 32'(q.iq_count), 32'd0);
        chk("flush keeps pc3", 32'(q.iq3_pc), 32'h13);
        chk("flush drop enq", 32'(q.iq0_pc), 32'h20);

        enq(16'hE000, 16'h0030);
        iss(2'd0); com(2'd0);
        chk("enq+ret pc", 32'(q.retire_pc), 32'h30);
        enq(16'hE001, 16'h0031);
        chk("enq+ret count", 32'(q.iq_count), 32'd1);
        chk("enq+ret rd", 32'(q.iq_rd), 32'd1);
        chk("enq+ret wr", 32'(q.iq_wr), 32'd2);

        rst = 1;
        tick();
        rst = 0;
        chk("rst2 pc1", 32'(q.iq1_pc), 32'd0);
        chk("rst2 count", 32'(q.iq_count), 32'd0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lc4_insn_queue.md
# lc4_insn_queue

Four-entry circular instruction queue for the out-of-order LC4 core. It accepts decoded instructions in program order from fetch/decode, tracks per-entry valid/issued/committed state, and retires committed entries from the head in order. Its slot contents, state vectors and head pointer directly feed the downstream memory-ordering selector and the issue logic.

## Interface
Parameters:
- INSN_W, 16, instruction width
- PC_W, 16, PC width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_insn  in  INSN_W  instruction to enqueue
- in_pc  in  PC_W  PC of that instruction
- in_ready  out  1  queue can accept (not full)
- issue_en  in  1  mark one entry issued
- issue_index  in  2  slot to mark issued
- commit_en  in  1  mark one entry committed
- commit_index  in  2  slot to mark committed
- flush  in  1  discard all entries
- iq0_insn..iq3_insn  out  INSN_W  slot instruction registers
- iq0_pc..iq3_pc  out  PC_W  slot PC registers
- iq_valid, iq_issue, iq_commit  out  4  per-slot state bits
- iq_rd  out  2  head (oldest) slot index
- iq_wr  out  2  tail (next free) slot index
- iq_count  out  3  occupied entries, 0..4
- retire_valid  out  1  head retired this cycle
- retire_pc  out  PC_W  PC of retired entry

## Operation
- All outputs reset to 0; in_ready is 1 after reset.
- Enqueue: when in_valid && in_ready, write insn/pc to slot iq_wr, set valid, clear issue/commit, advance iq_wr mod 4.
- in_ready = (iq_count != 4), derived from registered state. There is no same-cycle enqueue-on-retire when full.
- Issue: when issue_en is set and the slot is valid, set its issue bit. Issue to an invalid slot is ignored.
- Commit: when commit_en is set and the slot is valid and already issued, set its commit bit. Otherwise the commit is ignored.
- Retire: in a cycle where slot iq_rd has registered valid && commit, clear that slot's valid/issue/commit, advance iq_rd mod 4, and decrement count. retire_valid and retire_pc are combinational in that cycle.
- At most one retire per cycle, unless the macro below is defined.
- iq_count = enqueues − retires. Simultaneous enqueue and retire leaves the count unchanged.
- Pointers wrap 3→0. The full/empty distinction comes from iq_count, never from pointer equality.
- Flush (sync): clears all state bits, iq_rd = iq_wr = 0, count = 0, retire_valid = 0. Flush has priority over enqueue, issue, commit and retire in the same cycle.
- rst behaves identically to flush and also zeroes the slot data.
- Slot data is not cleared on retire or flush; downstream consumers qualify it with iq_valid.

## Timing
- Enqueue sampled at edge E: slot contents and valid bit are visible after E.
- Issue/commit sampled at E: the bit is visible after E.
- Retire: a commit sampled at E makes the head eligible in cycle E..E+1. The valid bit drops and iq_rd advances at E+1. Minimum commit-to-free latency is 1 cycle.
- Issue and commit to the same slot in the same cycle: the issue takes effect, the commit is ignored (not yet issued).
- Enqueue into a slot retiring in the same cycle cannot occur, because in_ready is low when full.

## Configuration
- LC4_IQ_DUAL_RETIRE_EN defined: if both slot iq_rd and slot iq_rd+1 are valid && committed, both retire in one cycle.
  - iq_rd advances by 2 and count decrements by 2.
  - Adds output retire2_valid and retire2_pc.
- Undefined: single retire per cycle, as above. retire2_* ports are absent.

## Structure
- Shared package lc4_iq_pkg holds:
  - constants IQ_DEPTH = 4 and IQ_IDX_W = 2
  - the slot struct typedef (insn, pc, valid, issue, commit)
- The shared package is used by this block and the memory-ordering selector.
- One sub-module, lc4_iq_slot, instantiated 4 times. It holds the slot registers and applies set/clear for write, issue, commit, retire and flush.
- The top level holds the pointers, count, in_ready and retire logic.

## Test plan
- Reset, then enqueue 4 insns (PCs 0x10–0x13) → iq_valid = 4'b1111, iq_count = 4, in_ready = 0, iq_wr = 0.
- Issue then commit slot 1 while slot 0 is uncommitted → no retire. Then commit slot 0 → slot 0 retires in the next cycle, then slot 1 in the cycle after, with retire_pc = 0x10, then 0x11.
- Commit slot 2 without a prior issue → iq_commit[2] stays 0.
- Wrap-around: full queue, retire 2, enqueue 2 → iq_rd = 2, iq_wr = 2, count = 4, and the new insns land in slots 0 and 1.
- Flush asserted in the same cycle as an enqueue and a head retire → all state is 0, iq_rd = iq_wr = 0, retire_valid = 0, and the enqueue is dropped.
- With LC4_IQ_DUAL_RETIRE_EN: commit slots 0 and 1 → both retire in one cycle, iq_rd = 2, count drops by 2.
